// File: rtl/chain_mon_pkg.sv
// Shared types for the chain edge monitor: FSM state encoding and the
// record layout pushed into the record FIFO.
package chain_mon_pkg;

  // Default interval width; the top re-declares the record with its own CNT_W.
  localparam int CNT_W_DEF = 16;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    STUCK = 2'd3
  } mon_state_e;

  // One activity record: edge polarity, first-edge flag, stall flag, interval.
  typedef struct packed {
    logic                 rise;
    logic                 first;
    logic                 stall;
    logic [CNT_W_DEF-1:0] interval;
  } edge_rec_t;

endpackage

// File: rtl/chain_edge_monitor_if.sv
// Record port of the chain edge monitor.
//
// Handshake: a record transfers on the rising clk edge where rec_valid and
// rec_ready are both 1. Once rec_valid is 1 the rec_* fields hold steady until
// that transfer, and rec_valid never depends combinationally on rec_ready.
interface chain_edge_monitor_if #(
  parameter int CNT_W = 16
) ();

  logic             rec_valid;
  logic             rec_ready;
  logic             rec_rise;
  logic             rec_first;
  logic             rec_stall;
  logic [CNT_W-1:0] rec_interval;

  // Record producer (the monitor).
  modport master (
    output rec_valid,
    output rec_rise,
    output rec_first,
    output rec_stall,
    output rec_interval,
    input  rec_ready
  );

  // Record consumer (the log collector).
  modport slave (
    input  rec_valid,
    input  rec_rise,
    input  rec_first,
    input  rec_stall,
    input  rec_interval,
    output rec_ready
  );

endinterface

// File: rtl/chain_edge_monitor_rec_fifo.sv
// First-word-fall-through record FIFO. Storage is registered and reset, so the
// head entry drives dout directly. Pointers carry one extra wrap bit: equal
// pointers mean empty, equal indices with differing wrap bits mean full.
// A push while full is accepted only when a pop happens in the same cycle.
module rec_fifo
  import chain_mon_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type rec_t = edge_rec_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  rec_t din,
  output logic full,
  input  logic pop,
  output rec_t dout,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  rec_t        r_mem [DEPTH];

  logic w_rd_en;
  logic w_wr_en;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd_en = pop & ~empty;
  assign w_wr_en = push & (~full | w_rd_en);
  assign dout    = r_mem[r_rd_ptr[AW-1:0]];

  // Advance read/write pointers on accepted pops and pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Record storage; cleared on reset so the head reads all-zero when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/chain_edge_monitor.sv
// Chain edge monitor: synchronizes the asynchronous delay-chain output,
// times the gap between transitions, flags stalls, and queues one record per
// edge or stall for the log collector.
module chain_edge_monitor
  import chain_mon_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000,
  parameter int DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        chain_in,
  chain_edge_monitor_if.master        rec,
  output logic [31:0]                 edge_count,
  output logic [15:0]                 drops,
  output logic                        stuck,
  output mon_state_e                  o_dbg_state
);

  // Record layout sized by this instance's interval width.
  typedef struct packed {
    logic             rise;
    logic             first;
    logic             stall;
    logic [CNT_W-1:0] interval;
  } rec_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  mon_state_e       r_state;
  mon_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_edge;
  logic             w_stall_push;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;
  rec_t             w_din;
  rec_t             w_dout;
  logic [31:0]      r_edge_count;
  logic [15:0]      r_drops;

  // Two-flop synchronizer plus a history flop for edge detection; runs always.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= chain_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // An edge counts only while enabled and out of IDLE.
  assign w_edge       = en && (r_state != IDLE) && (r_s2 != r_s3);
  // Stall fires once, on the cycle the gap reaches TIMEOUT without an edge.
  assign w_stall_push = en && ((r_state == ARMED) || (r_state == RUN)) &&
                        !w_edge && (r_cnt == TO_LAST);
  assign w_cnt_inc    = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: disable wins, then edges, then the stall timeout.
  always_comb begin
    w_state_nxt = r_state;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:       w_state_nxt = ARMED;
        ARMED, RUN: begin
          if (w_edge)            w_state_nxt = RUN;
          else if (w_stall_push) w_state_nxt = STUCK;
        end
        STUCK:      if (w_edge) w_state_nxt = RUN;
        default:    w_state_nxt = IDLE;
      endcase
    end
  end

  // Interval counter: held at zero in IDLE, restarted by each edge, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (!en || r_state == IDLE)  r_cnt <= '0;
    else if (w_edge)                  r_cnt <= '0;
    else                              r_cnt <= w_cnt_inc;
  end

  // Record assembly: edge records carry polarity and measured gap,
  // stall records carry the fixed TIMEOUT interval.
  always_comb begin
    w_din          = '0;
    w_din.rise     = w_edge & r_s2;
    w_din.first    = w_edge & (r_state == ARMED);
    w_din.stall    = w_stall_push;
    w_din.interval = w_edge ? w_cnt_inc : TO_VAL;
  end

  assign w_push = w_edge | w_stall_push;
  assign w_pop  = rec.rec_ready & ~w_empty;
  assign w_drop = w_push & w_full & ~w_pop;

  rec_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_rec_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .din   (w_din),
    .full  (w_full),
    .pop   (w_pop),
    .dout  (w_dout),
    .empty (w_empty)
  );

  // Statistics: wrapping edge counter (dropped edges included), saturating drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_count <= '0;
      r_drops      <= '0;
    end else begin
      if (w_edge) r_edge_count <= r_edge_count + 32'd1;
      if (w_drop && (r_drops != 16'hFFFF)) r_drops <= r_drops + 16'd1;
    end
  end

  assign rec.rec_valid    = ~w_empty;
  assign rec.rec_rise     = w_dout.rise;
  assign rec.rec_first    = w_dout.first;
  assign rec.rec_stall    = w_dout.stall;
  assign rec.rec_interval = w_dout.interval;

  assign edge_count  = r_edge_count;
  assign drops       = r_drops;
  assign stuck       = (r_state == STUCK);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_chain_edge_monitor.sv
// Directed bench for chain_edge_monitor (CNT_W=16, TIMEOUT=20, DEPTH=4).
// Inputs change 1 time unit after a rising edge; records are compared on the
// falling edge before the transfer edge against an expected queue.
module tb_chain_edge_monitor;
  import chain_mon_pkg::*;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 20;
  localparam int DEPTH   = 4;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic        en       = 1'b0;
  logic        chain_in = 1'b0;
  logic [31:0] edge_count;
  logic [15:0] drops;
  logic        stuck;
  mon_state_e  dbg_state;

  chain_edge_monitor_if #(.CNT_W(CNT_W)) rec_if ();

  chain_edge_monitor #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .chain_in    (chain_in),
    .rec         (rec_if),
    .edge_count  (edge_count),
    .drops       (drops),
    .stuck       (stuck),
    .o_dbg_state (dbg_state)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  int          n_tests   = 0;
  int          n_fail    = 0;
  int          exp_edges = 0;
  int          exp_drops = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic rise, input logic first,
                                     input logic stall, input int interval);
    return {13'd0, rise, first, stall, interval[15:0]};
  endfunction

  // Advance n rising edges and land 1 unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every transfer must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && rec_if.rec_valid && rec_if.rec_ready) begin
      if (exp_q.size() == 0)
        check("unexpected record valid", 32'(rec_if.rec_valid), 32'd0);
      else
        check("record", {13'd0, rec_if.rec_rise, rec_if.rec_first,
                         rec_if.rec_stall, rec_if.rec_interval}, exp_q.pop_front());
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_if.rec_ready = 1'b0;
    // ---- reset values ----
    #2 rst_n = 1'b0;
    #1;
    check("rst rec_valid",    32'(rec_if.rec_valid),    32'd0);
    check("rst rec_rise",     32'(rec_if.rec_rise),     32'd0);
    check("rst rec_first",    32'(rec_if.rec_first),    32'd0);
    check("rst rec_stall",    32'(rec_if.rec_stall),    32'd0);
    check("rst rec_interval", 32'(rec_if.rec_interval), 32'd0);
    check("rst edge_count",   edge_count,               32'd0);
    check("rst drops",        32'(drops),               32'd0);
    check("rst stuck",        32'(stuck),               32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // ---- T1: toggle every 10 clk, consumer always ready ----
    // First toggle 8 cycles after enable: 1 cycle to ARMED, 2 synchronizer
    // cycles to the record, so the first interval is also 10.
    rec_if.rec_ready = 1'b1;
    en = 1'b1;
    tick(8);
    chain_in = 1'b1; exp_edges++;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 10));
    for (int i = 1; i < 6; i++) begin
      tick(10);
      chain_in = ~chain_in; exp_edges++;
      exp_q.push_back(mk(chain_in, 1'b0, 1'b0, 10));
    end
    tick(5);
    check("t1 edge_count", edge_count, 32'(exp_edges));
    check("t1 drained",    32'(exp_q.size()), 32'd0);
    en = 1'b0;
    tick(2);

    // ---- T2: held input -> one stall record, then an edge ends STUCK ----
    en = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, TIMEOUT));
    tick(30);
    check("t2 stuck",  32'(stuck), 32'd1);
    check("t2 state",  32'(dbg_state), 32'(STUCK));
    tick(18);
    // Toggle 48 cycles after enable: ARMED at +1, record written at +51.
    chain_in = 1'b1; exp_edges++;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 50));
    tick(7);
    check("t2 unstuck", 32'(stuck), 32'd0);
    check("t2 drained", 32'(exp_q.size()), 32'd0);
    en = 1'b0;
    tick(2);

    // ---- T3: consumer stalled, 6 edges into a 4-deep FIFO ----
    rec_if.rec_ready = 1'b0;
    en = 1'b1;
    tick(8);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick(10);
      chain_in = ~chain_in; exp_edges++;
      if (i < DEPTH) exp_q.push_back(mk(chain_in, (i == 0), 1'b0, 10));
      else           exp_drops++;
    end
    tick(5);
    en = 1'b0;
    check("t3 drops",      32'(drops), 32'(exp_drops));
    check("t3 edge_count", edge_count, 32'(exp_edges));
    check("t3 valid held", 32'(rec_if.rec_valid), 32'd1);
    rec_if.rec_ready = 1'b1;
    tick(8);
    check("t3 drained",  32'(exp_q.size()), 32'd0);
    check("t3 empty",    32'(rec_if.rec_valid), 32'd0);

    // ---- T4: full FIFO, pop coincides with a new push ----
    rec_if.rec_ready = 1'b0;
    en = 1'b1;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick(10);
      chain_in = ~chain_in; exp_edges++;
      exp_q.push_back(mk(chain_in, (i == 0), 1'b0, 10));
    end
    tick(10);
    chain_in = ~chain_in; exp_edges++;
    exp_q.push_back(mk(chain_in, 1'b0, 1'b0, 10));
    tick(2);
    rec_if.rec_ready = 1'b1;   // single-cycle pop on the push edge
    tick(1);
    rec_if.rec_ready = 1'b0;
    check("t4 drops unchanged", 32'(drops), 32'(exp_drops));
    tick(7);
    // FIFO should still hold 4, so this edge is dropped.
    chain_in = ~chain_in; exp_edges++; exp_drops++;
    tick(5);
    en = 1'b0;
    check("t4 drops after full", 32'(drops), 32'(exp_drops));
    check("t4 edge_count",       edge_count, 32'(exp_edges));
    rec_if.rec_ready = 1'b1;
    tick(8);
    check("t4 drained", 32'(exp_q.size()), 32'd0);

    // ---- T5: asynchronous reset with 3 records queued ----
    rec_if.rec_ready = 1'b0;
    en = 1'b1;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick(10);
      chain_in = ~chain_in;
    end
    tick(5);
    check("t5 queued valid", 32'(rec_if.rec_valid), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t5 rec_valid",    32'(rec_if.rec_valid),    32'd0);
    check("t5 rec_rise",     32'(rec_if.rec_rise),     32'd0);
    check("t5 rec_first",    32'(rec_if.rec_first),    32'd0);
    check("t5 rec_interval", 32'(rec_if.rec_interval), 32'd0);
    check("t5 edge_count",   edge_count,               32'd0);
    check("t5 drops",        32'(drops),               32'd0);
    check("t5 stuck",        32'(stuck),               32'd0);
    exp_edges = 0;
    exp_drops = 0;
    en = 1'b0;
    chain_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    rec_if.rec_ready = 1'b1;
    tick(5);
    check("t5 no residual", 32'(rec_if.rec_valid), 32'd0);

    // ---- T6: half-period pulses ----
    en = 1'b1;
    tick(8);
    // Pulse straddling one rising edge: sampled once -> rise then fall.
    #6 chain_in = 1'b1;
    #5 chain_in = 1'b0;
    exp_edges += 2;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 10));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1));
    tick(9);
    check("t6 edge_count",  edge_count, 32'(exp_edges));
    check("t6 even",        32'(edge_count[0]), 32'd0);
    // Pulse between rising edges: never sampled.
    chain_in = 1'b1;
    #5 chain_in = 1'b0;
    tick(4);
    check("t6 no new edge", edge_count, 32'(exp_edges));
    check("t6 no X", 32'($isunknown({rec_if.rec_valid, rec_if.rec_rise, rec_if.rec_first,
                                     rec_if.rec_stall, rec_if.rec_interval,
                                     edge_count, drops, stuck})), 32'd0);
    check("t6 drained", 32'(exp_q.size()), 32'd0);
    en = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
